// File: rtl/ldpc_iter_ctrl_if.sv
// Demapper/core side bundle for ldpc_iter_ctrl: frame input, iteration handshakes, LLR load port, status.
// The master modport drives the frame and core feedback; the slave modport is the controller.
interface ldpc_iter_ctrl_if #(
  parameter int D_WID  = 6,
  parameter int ADDR_W = 14
);
  logic [D_WID-1:0]  data_in;
  logic              sync_in;
  logic              rate;
  logic [4:0]        max_iter;
  logic              chk_done;
  logic              chk_pass;
  logic              out_done;

  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [D_WID-1:0]  load_data;
  logic              rate_q;
  logic              iter_start;
  logic              out_start;
  logic              busy;
  logic [4:0]        num_iter;
  logic              frm_err;
  logic              drop;

  modport master (
    output data_in, sync_in, rate, max_iter, chk_done, chk_pass, out_done,
    input  load_en, load_addr, load_data, rate_q, iter_start, out_start,
           busy, num_iter, frm_err, drop
  );

  modport slave (
    input  data_in, sync_in, rate, max_iter, chk_done, chk_pass, out_done,
    output load_en, load_addr, load_data, rate_q, iter_start, out_start,
           busy, num_iter, frm_err, drop
  );
endinterface

// File: rtl/ldpc_iter_ctrl.sv
// LDPC frame sequencer: loads one frame of LLRs, runs iterations until max or (LDPC_EARLY_STOP_EN) parity pass.
// Load path 1 cycle; chk_done -> next start 2 cycles; no backpressure, samples arriving while busy are dropped.
module ldpc_iter_ctrl #(
  parameter int D_WID     = 6,
  parameter int FRAME_LEN = 9216,
  parameter int ADDR_W    = 14
) (
  input  logic                clk,
  input  logic                reset,
  ldpc_iter_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, WAIT, OUT} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_cnt, wr_cnt_nx;
  logic [4:0]        iter_cnt, iter_cnt_nx;
  logic [4:0]        max_lat, max_lat_nx;
  logic              out_pend, out_pend_nx;

  logic              load_en_q, load_en_nx;
  logic [ADDR_W-1:0] load_addr_q, load_addr_nx;
  logic [D_WID-1:0]  load_data_q, load_data_nx;
  logic              rate_q_q, rate_q_nx;
  logic              iter_start_q, iter_start_nx;
  logic              out_start_q, out_start_nx;
  logic              busy_q, busy_nx;
  logic [4:0]        num_iter_q, num_iter_nx;
  logic              frm_err_q, frm_err_nx;
  logic              drop_q, drop_nx;

  logic [4:0]        iter_inc;
  logic              early;
  logic              stop;

`ifdef LDPC_EARLY_STOP_EN
  assign early = bus.chk_pass;
`else
  assign early = 1'b0;
`endif

  assign iter_inc = iter_cnt + 5'd1;
  assign stop     = early | (iter_inc == max_lat);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_cnt       <= '0;
      iter_cnt     <= '0;
      max_lat      <= '0;
      out_pend     <= 1'b0;
      load_en_q    <= 1'b0;
      load_addr_q  <= '0;
      load_data_q  <= '0;
      rate_q_q     <= 1'b0;
      iter_start_q <= 1'b0;
      out_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      num_iter_q   <= '0;
      frm_err_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state        <= state_nx;
      wr_cnt       <= wr_cnt_nx;
      iter_cnt     <= iter_cnt_nx;
      max_lat      <= max_lat_nx;
      out_pend     <= out_pend_nx;
      load_en_q    <= load_en_nx;
      load_addr_q  <= load_addr_nx;
      load_data_q  <= load_data_nx;
      rate_q_q     <= rate_q_nx;
      iter_start_q <= iter_start_nx;
      out_start_q  <= out_start_nx;
      busy_q       <= busy_nx;
      num_iter_q   <= num_iter_nx;
      frm_err_q    <= frm_err_nx;
      drop_q       <= drop_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    wr_cnt_nx     = wr_cnt;
    iter_cnt_nx   = iter_cnt;
    max_lat_nx    = max_lat;
    out_pend_nx   = 1'b0;
    load_en_nx    = 1'b0;
    load_addr_nx  = load_addr_q;
    load_data_nx  = load_data_q;
    rate_q_nx     = rate_q_q;
    iter_start_nx = 1'b0;
    // out_start trails the WAIT->OUT transition by one cycle to match iter_start timing
    out_start_nx  = out_pend;
    num_iter_nx   = num_iter_q;
    frm_err_nx    = 1'b0;
    drop_nx       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.sync_in) begin
          rate_q_nx    = bus.rate;
          max_lat_nx   = (bus.max_iter == 5'd0) ? 5'd1 : bus.max_iter;
          load_en_nx   = 1'b1;
          load_addr_nx = '0;
          load_data_nx = bus.data_in;
          wr_cnt_nx    = ADDR_W'(1);
          state_nx     = (FRAME_LEN == 1) ? ITER : LOAD;
        end
      end
      LOAD: begin
        if (bus.sync_in) begin
          load_en_nx   = 1'b1;
          load_addr_nx = wr_cnt;
          load_data_nx = bus.data_in;
          wr_cnt_nx    = wr_cnt + 1'b1;
          if (wr_cnt == LAST_ADDR) state_nx = ITER;
        end else begin
          // short frame: discard, leave iteration count and num_iter alone
          frm_err_nx = 1'b1;
          state_nx   = IDLE;
        end
      end
      ITER: begin
        drop_nx       = bus.sync_in;
        iter_start_nx = 1'b1;
        state_nx      = WAIT;
      end
      WAIT: begin
        drop_nx = bus.sync_in;
        if (bus.chk_done) begin
          iter_cnt_nx = iter_inc;
          if (stop) begin
            state_nx    = OUT;
            out_pend_nx = 1'b1;
            num_iter_nx = iter_inc;
          end else begin
            state_nx = ITER;
          end
        end
      end
      OUT: begin
        drop_nx = bus.sync_in;
        if (bus.out_done) begin
          state_nx    = IDLE;
          iter_cnt_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  assign bus.load_en    = load_en_q;
  assign bus.load_addr  = load_addr_q;
  assign bus.load_data  = load_data_q;
  assign bus.rate_q     = rate_q_q;
  assign bus.iter_start = iter_start_q;
  assign bus.out_start  = out_start_q;
  assign bus.busy       = busy_q;
  assign bus.num_iter   = num_iter_q;
  assign bus.frm_err    = frm_err_q;
  assign bus.drop       = drop_q;

endmodule

// File: doc/ldpc_iter_ctrl.md
# ldpc_iter_ctrl

Frame-level sequencer for the LDPC decoder core. It accepts a soft-decision frame stream (`data_in`/`sync_in`) and writes it into the core's channel-LLR memory. It then runs the decoding iterations, stopping on a parity-check pass or at `max_iter`, and hands off to the output unloader while reporting `busy` and `num_iter`. It sits between the demapper interface and the `ldpc` core datapath, replacing ad-hoc frame control inside the core.

## Interface
Parameters:
- `D_WID`, 6: soft-value width.
- `FRAME_LEN`, 9216: samples per codeword.
- `ADDR_W`, 14: load address width; must satisfy 2^ADDR_W ≥ FRAME_LEN.

Ports:
- `clk`, input, 1: clock; all logic rising-edge.
- `reset`, input, 1: synchronous, active-high reset.
- `data_in`, input, D_WID: soft sample, valid when `sync_in`=1.
- `sync_in`, input, 1: sample valid; high for exactly FRAME_LEN consecutive cycles per frame.
- `rate`, input, 1: code rate select, sampled on the first sample of a frame.
- `max_iter`, input, 5: iteration limit, sampled on the first sample of a frame.
- `chk_done`, input, 1: one-cycle pulse from the core marking the end of one iteration.
- `chk_pass`, input, 1: all parity checks satisfied; qualified by `chk_done`.
- `out_done`, input, 1: one-cycle pulse from the unloader when the hard-decision output is complete.
- `load_en`, output, 1: LLR memory write enable.
- `load_addr`, output, ADDR_W: LLR memory write address.
- `load_data`, output, D_WID: registered copy of `data_in`.
- `rate_q`, output, 1: latched rate, held for the whole frame.
- `iter_start`, output, 1: one-cycle pulse that starts one core iteration.
- `out_start`, output, 1: one-cycle pulse that starts the unloader.
- `busy`, output, 1: a frame is in progress.
- `num_iter`, output, 5: number of iterations run on the last completed frame.
- `frm_err`, output, 1: one-cycle pulse on a short frame.
- `drop`, output, 1: one-cycle pulse when `sync_in` arrives while the block is busy and not loading.

## Operation
- States: IDLE, LOAD, ITER, WAIT, OUT.
- IDLE:
  - `sync_in`=1 → latch `rate_q`, latch max_iter (value 0 is treated as 1), write sample 0, go to LOAD.
- LOAD:
  - Each `sync_in`=1 cycle writes the next address.
  - When address FRAME_LEN-1 is written → go to ITER.
  - `sync_in`=0 before FRAME_LEN samples → pulse `frm_err`, go to IDLE. The partial frame is discarded and `iter_cnt` is not touched.
- ITER: pulse `iter_start`, go to WAIT.
- WAIT, on `chk_done`:
  - Increment `iter_cnt`.
  - If (`chk_pass` and `LDPC_EARLY_STOP_EN`) or `iter_cnt`+1 = latched max → go to OUT, pulse `out_start`, load `num_iter` with `iter_cnt`+1.
  - Otherwise → go to ITER.
- OUT: `out_done` → go to IDLE and clear `iter_cnt`.
- `chk_done` outside WAIT and `out_done` outside OUT are ignored.
- `sync_in`=1 in ITER, WAIT or OUT → pulse `drop`; the sample is ignored.
- `num_iter` holds its value until the next frame completes; aborted frames leave it unchanged.

## Timing
- Reset values: all outputs 0, state IDLE, `iter_cnt` 0.
- Any cycle with `reset`=1 returns the block to IDLE and clears all outputs, including mid-frame.
- Load path: `sync_in` sampled at edge k → `load_en`/`load_addr`/`load_data` valid in cycle k+1.
- Frame with first sample at edge k:
  - Last write is in cycle k+FRAME_LEN.
  - `iter_start` is in cycle k+FRAME_LEN+1.
  - `busy` rises in cycle k+1.
- `chk_done` at cycle t → next `iter_start` or `out_start` at cycle t+2.
- `num_iter` is valid from the `out_start` cycle.
- `out_done` at cycle u → `busy`=0 in cycle u+1. `sync_in` at edge u+1 is accepted as a new frame. Back-to-back frames need ≥1 idle cycle after `out_done`.
- `frm_err` asserts the cycle after `sync_in` drops; `busy` is 0 in that same cycle.

## Configuration
- `LDPC_EARLY_STOP_EN` defined: `chk_pass` with `chk_done` terminates decoding early.
- Undefined: `chk_pass` is ignored, and exactly the latched max_iter iterations always run (`num_iter` = max_iter, or 1 when max_iter is 0).

## Test plan
- Full frame, FRAME_LEN samples, max_iter=20, `chk_pass` never asserted → 9216 writes at addresses 0..9215, 20 `iter_start` pulses, one `out_start`, `num_iter`=20.
- Same frame with EN defined, `chk_pass`=1 on the 3rd `chk_done` → exactly 3 `iter_start` pulses, `num_iter`=3. With EN undefined → 20 pulses.
- `sync_in` drops after 100 samples → `frm_err` pulse, `busy`=0, `num_iter` unchanged. The next full frame then loads from address 0.
- max_iter=0 → 1 iteration, `num_iter`=1. `rate`=1 on the first sample and toggled mid-frame → `rate_q` stays 1.
- `sync_in` pulsed in WAIT → `drop`=1 for one cycle, with no write and no state change.
- `reset` asserted in the middle of WAIT → next cycle all outputs are 0 and the state is IDLE. A fresh frame then decodes normally.
